// File: rtl/gbc_lcd_scanout.sv
// gbc_lcd_scanout: Wishbone pixel target feeding a double-banked 160-pixel
// scanline buffer, scanned out as a 160x144 raster with DotEn-paced timing.
// Optional feature: define LCD_SCANOUT_UNDERRUN_EN to track per-word valid
// bits and count reads of pixels that were never refreshed.
module gbc_lcd_scanout #(
    parameter int H_TOTAL      = 456,
    parameter int H_SYNC_START = 176,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 154,
    parameter int V_SYNC_START = 146,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        doten,
    input  logic        pix_cyc,
    input  logic        pix_stb,
    input  logic        pix_we,
    input  logic [15:0] pix_adr,
    input  logic [15:0] pix_dat_i,
    output logic [15:0] pix_dat_o,
    output logic        pix_ack,
    output logic        pix_stall,
    output logic [4:0]  r,
    output logic [4:0]  g,
    output logic [4:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        framestart,
    output logic [15:0] underrun_count
);

    localparam logic [8:0] HLAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] HS0   = 9'(H_SYNC_START);
    localparam logic [8:0] HS1   = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [7:0] VLAST = 8'(V_TOTAL - 1);
    localparam logic [7:0] VS0   = 8'(V_SYNC_START);
    localparam logic [7:0] VS1   = 8'(V_SYNC_START + V_SYNC_LEN);

    logic [8:0]  hcnt;
    logic [7:0]  vcnt;
    logic        active;
    logic [7:0]  wx, wy;
    logic        req, accept, wr_en;
    logic        rd_bank;
    logic [7:0]  rd_idx;
    logic [14:0] rd_word;
    logic        word_ok;
    logic        unused_dat;

    // Two line banks; bank = line number bit 0. Not cleared by reset.
    logic [14:0] mem [0:1][0:159];

    assign active  = (hcnt < 9'd160) && (vcnt < 8'd144);
    assign wx      = pix_adr[7:0];
    assign wy      = pix_adr[15:8];
    assign req     = pix_cyc & pix_stb;
    // Hold the writer off the bank that is currently being displayed.
    assign pix_stall = req & (pix_adr[8] == vcnt[0]) & active;
    assign accept  = req & ~pix_stall;
    assign wr_en   = accept & pix_we & (wx < 8'd160) & (wy < 8'd144);
    assign rd_bank = vcnt[0];
    assign rd_idx  = hcnt[7:0];
    assign rd_word = mem[rd_bank][rd_idx];
    assign pix_dat_o  = 16'h0000;
    assign unused_dat = pix_dat_i[15];

    // Buffer write port
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wy[0]][wx] <= pix_dat_i[14:0];
    end

    // Dot counters, advanced only by DotEn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (doten) begin
            if (hcnt == HLAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == VLAST) ? 8'd0 : vcnt + 8'd1;
            end else begin
                hcnt <= hcnt + 9'd1;
            end
        end
    end

    // One ACK per accepted request, one cycle later, regardless of DotEn
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix_ack <= 1'b0;
        else     pix_ack <= accept;
    end

`ifdef LCD_SCANOUT_UNDERRUN_EN
    logic [1:0][159:0] vbit;
    logic [15:0]       ucnt;

    assign word_ok        = vbit[rd_bank][rd_idx];
    assign underrun_count = ucnt;

    // Valid bits: set by a write, consumed by the scan-out read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vbit <= '0;
        end else begin
            if (doten && active)
                vbit[rd_bank][rd_idx] <= 1'b0;
            if (wr_en)
                vbit[wy[0]][wx] <= 1'b1;
        end
    end

    // Saturating count of stale pixels hit during the active region
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ucnt <= '0;
        else if (doten && active && !word_ok && ucnt != 16'hFFFF)
            ucnt <= ucnt + 16'd1;
    end
`else
    assign word_ok        = 1'b1;
    assign underrun_count = 16'h0000;
`endif

    // Registered video outputs for the pre-increment dot position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r          <= '0;
            g          <= '0;
            b          <= '0;
            de         <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            framestart <= 1'b0;
        end else if (doten) begin
            de         <= active;
            hsync      <= (hcnt >= HS0) && (hcnt < HS1);
            vsync      <= (vcnt >= VS0) && (vcnt < VS1);
            framestart <= (hcnt == 9'd0) && (vcnt == 8'd0);
            if (active && word_ok) begin
                r <= rd_word[14:10];
                g <= rd_word[9:5];
                b <= rd_word[4:0];
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end else begin
            framestart <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gbc_lcd_scanout.sv
// Self-checking bench for gbc_lcd_scanout: directed phases plus random
// traffic, checked against a raster/buffer model kept in plain integers.
module tb_gbc_lcd_scanout;

    logic        clk = 1'b0;
    logic        rst;
    logic        doten;
    logic        pix_cyc, pix_stb, pix_we;
    logic [15:0] pix_adr, pix_dat_i;
    logic [15:0] pix_dat_o;
    logic        pix_ack, pix_stall;
    logic [4:0]  r, g, b;
    logic        hsync, vsync, de, framestart;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    // model state
    int          mh, mv, mund;
    logic [14:0] mmem [2][160];
    bit          mknown [2][160];
    bit          mvalid [2][160];
    logic [14:0] ergb;
    bit          erk, ede, ehs, evs, efs, eack;
    bit          last_stall;
    int          fs_seen, vs_cycles, hs_cycles;

    gbc_lcd_scanout dut (
        .clk(clk), .rst(rst), .doten(doten),
        .pix_cyc(pix_cyc), .pix_stb(pix_stb), .pix_we(pix_we),
        .pix_adr(pix_adr), .pix_dat_i(pix_dat_i), .pix_dat_o(pix_dat_o),
        .pix_ack(pix_ack), .pix_stall(pix_stall),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
        .framestart(framestart), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mund = 0;
        ergb = '0; erk = 1; ede = 0; ehs = 0; evs = 0; efs = 0; eack = 0;
        for (int k = 0; k < 2; k++)
            for (int x = 0; x < 160; x++) mvalid[k][x] = 0;
    endtask

    task automatic check_outs();
        chk("ack", {31'd0, pix_ack}, {31'd0, eack});
        chk("de", {31'd0, de}, {31'd0, ede});
        chk("hsync", {31'd0, hsync}, {31'd0, ehs});
        chk("vsync", {31'd0, vsync}, {31'd0, evs});
        chk("framestart", {31'd0, framestart}, {31'd0, efs});
        chk("underrun", {16'd0, underrun_count}, mund);
        if (erk) chk("rgb", {17'd0, r, g, b}, {17'd0, ergb});
    endtask

    // One clock: drive inputs, check STALL, predict, cross the edge, check.
    task automatic tick(input bit den, input bit c, input bit s, input bit w,
                        input logic [15:0] a, input logic [15:0] d);
        bit busy, stl, acc, act;
        int x, y, bk;
        doten = den; pix_cyc = c; pix_stb = s; pix_we = w;
        pix_adr = a; pix_dat_i = d;
        #1;
        busy = (mv < 144) && (mh < 160);
        stl  = c && s && (int'(a[8]) == mv % 2) && busy;
        last_stall = pix_stall;
        chk("stall", {31'd0, pix_stall}, {31'd0, stl});
        acc  = c && s && !stl;
        eack = acc;
        efs  = 0;
        if (den) begin
            act = (mh < 160) && (mv < 144);
            ede = act;
            ehs = (mh >= 176) && (mh < 208);
            evs = (mv >= 146) && (mv < 149);
            efs = (mh == 0) && (mv == 0);
            if (act) begin
                bk   = mv % 2;
                ergb = mmem[bk][mh];
                erk  = mknown[bk][mh];
`ifdef LCD_SCANOUT_UNDERRUN_EN
                if (!mvalid[bk][mh]) begin
                    ergb = '0;
                    if (mund < 65535) mund++;
                end
                erk = 1;
                mvalid[bk][mh] = 0;
`endif
            end else begin
                ergb = '0;
                erk  = 1;
            end
            mh++;
            if (mh == 456) begin
                mh = 0;
                mv = (mv == 153) ? 0 : mv + 1;
            end
        end
        if (acc && w) begin
            x = int'(a[7:0]);
            y = int'(a[15:8]);
            if (x < 160 && y < 144) begin
                mmem[y % 2][x]   = d[14:0];
                mknown[y % 2][x] = 1;
                mvalid[y % 2][x] = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outs();
        if (framestart === 1'b1) fs_seen++;
        if (vsync === 1'b1) vs_cycles++;
        if (hsync === 1'b1) hs_cycles++;
    endtask

    initial begin
        int stall_cnt, iter;
        logic [15:0] d;
        for (int k = 0; k < 2; k++)
            for (int x = 0; x < 160; x++) begin
                mknown[k][x] = 0;
                mmem[k][x]   = '0;
            end

        // reset asserted while a write request is held
        rst = 1; doten = 1; pix_cyc = 1; pix_stb = 1; pix_we = 1;
        pix_adr = {8'd1, 8'd0}; pix_dat_i = 16'h1234;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        chk("dat_o", {16'd0, pix_dat_o}, 32'd0);
        pix_cyc = 0; pix_stb = 0; doten = 0;
        #2 rst = 0;

        // first 160 dots of line 0: first DE pixel and FrameStart at (0,0)
        for (int i = 0; i < 160; i++) tick(1, 0, 0, 0, 16'h0, 16'h0);

        // fill line 0 with x, line 1 with random colours; out-of-range writes
        for (int x = 0; x < 160; x++) begin
            d = 16'(x) | (16'($urandom_range(0, 1)) << 15);
            tick(0, 1, 1, 1, {8'd0, 8'(x)}, d);
        end
        for (int x = 0; x < 160; x++)
            tick(0, 1, 1, 1, {8'd1, 8'(x)}, 16'($urandom));
        tick(0, 1, 1, 1, {8'd0, 8'd160}, 16'h7FFF);
        tick(0, 1, 1, 1, {8'd144, 8'd0}, 16'h7FFF);
        tick(0, 1, 1, 0, {8'd0, 8'd3}, 16'h0);

        // continuous scan through the rest of the frame, then dot (0,0)
        fs_seen = 0; vs_cycles = 0;
        for (int i = 0; i < 456 * 154 - 160 + 1; i++) tick(1, 0, 0, 0, 16'h0, 16'h0);
        chk("framestart_per_frame", fs_seen, 1);
        chk("vsync_cycles", vs_cycles, 3 * 456);

        // line 0 of the next frame at one dot per 4 clocks
        hs_cycles = 0;
        for (int k = 0; k < 455 * 4; k++) tick(k % 4 == 0, 0, 0, 0, 16'h0, 16'h0);
        chk("hsync_cycles", hs_cycles, 32 * 4);

        // move to line 2, dot 50; bank 0 is being displayed
        for (int i = 0; i < 456 + 50; i++) tick(1, 0, 0, 0, 16'h0, 16'h0);
        tick(0, 1, 1, 1, {8'd1, 8'd7}, 16'h2A55);
        chk("other_bank_no_stall", {31'd0, last_stall}, 32'd0);
        stall_cnt = 0; iter = 0;
        do begin
            tick(1, 1, 1, 1, {8'd4, 8'd9}, 16'h1ABC);
            if (last_stall) stall_cnt++;
            iter++;
        end while (last_stall && iter < 200);
        chk("stall_cycles", stall_cnt, 110);
        tick(1, 0, 0, 0, 16'h0, 16'h0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 {8'($urandom_range(0, 150)), 8'($urandom_range(0, 170))},
                 16'($urandom));
        end

        // reset in the middle of an accepted write
        tick(1, 1, 1, 1, {8'd1, 8'd5}, 16'h3210);
        #3 rst = 1;
        #1 model_reset();
        check_outs();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        pix_cyc = 0; pix_stb = 0; doten = 0;
        #2 rst = 0;
        fs_seen = 0;
        for (int i = 0; i < 600; i++)
            tick(1, $urandom_range(0, 1) == 1, 1, 1,
                 {8'($urandom_range(0, 3)), 8'($urandom_range(0, 159))}, 16'($urandom));
        chk("framestart_after_reset", fs_seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
